lms_backward: RTL and testbench

//  Backward (adaptation) half of the LMS system-identification loop; feedForward is the forward half.
//  - Takes one sample tuple: plant output y, forward estimate y_hat, and regressors x[n-1], y[n-1].
//  - Computes the error e = y - y_hat.
//  - Updates the coefficient estimates a_hat, b_hat by the sign-preserving LMS rule.
//  - Feeds a_hat, b_hat back to feedForward. Multi-cycle datapath with a valid/ready input handshake.

---
 rtl/lms_pkg.sv | 23 ++
 rtl/lms_coef_upd.sv | 46 ++++
 rtl/lms_backward.sv | 107 ++++++++++
 tb/tb_lms_backward.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/lms_pkg.sv
// Shared LMS definitions: default width, FSM state encoding and the signed clamp helper.
package lms_pkg;

  localparam int DW_DEF = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ERR  = 2'd1;
  localparam logic [1:0] S_GRAD = 2'd2;
  localparam logic [1:0] S_UPD  = 2'd3;

  // Clamp a signed value into the range of a w-bit two's-complement number.
  function automatic logic signed [31:0] sat_dw(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    if (x > hi)
      return hi;
    else if (x < -hi - 32'sd1)
      return -hi - 32'sd1;
    else
      return x;
  endfunction

endpackage

// File: rtl/lms_coef_upd.sv
// One LMS coefficient register: shifts the raw gradient product by mu and accumulates it.
// LMS_SAT_EN selects clamping of gradient and sum; otherwise both are truncated (wrap).
module lms_coef_upd
  import lms_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int MU_SHIFT = 2,
  parameter int INIT     = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            upd,
  input  logic            en,
  input  logic [2*DW:0]   prod,
  output logic [DW-1:0]   coef
);

  localparam int GW = DW + 1;
  localparam int SW = DW + 2;

  logic signed [2*DW:0] g_full;
  logic signed [GW-1:0] g;
  logic signed [SW-1:0] sum;
  logic [DW-1:0]        coef_nxt;

  // Arithmetic shift floors toward -inf, matching mu = 2^-MU_SHIFT on a signed gradient.
  assign g_full = $signed(prod) >>> MU_SHIFT;

`ifdef LMS_SAT_EN
  assign g        = GW'(sat_dw(32'(g_full), DW));
  assign sum      = SW'($signed(coef)) + SW'(g);
  assign coef_nxt = DW'(sat_dw(32'(sum), DW));
`else
  assign g        = GW'(g_full);
  assign sum      = SW'($signed(coef)) + SW'(g);
  assign coef_nxt = DW'(sum);
`endif

  always_ff @(posedge clk) begin
    if (rst)
      coef <= DW'(INIT);
    else if (upd && en)
      coef <= coef_nxt;
  end

endmodule

// File: rtl/lms_backward.sv
// LMS backward half: error, gradient and coefficient update over IDLE->ERR->GRAD->UPD.
// Optional clamping of the update is enabled by defining LMS_SAT_EN.
module lms_backward
  import lms_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int MU_SHIFT = 2,
  parameter int A_INIT   = 0,
  parameter int B_INIT   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_x_last,
  input  logic [DW-1:0] in_y_last,
  input  logic [DW-1:0] in_y_current,
  input  logic [DW-1:0] in_y_hat,
  input  logic          freeze,
  output logic [DW-1:0] a_hat,
  output logic [DW-1:0] b_hat,
  output logic [DW:0]   err,
  output logic          coef_valid
);

  localparam int PW = 2 * DW + 1;

  logic [1:0]          state, state_nxt;
  logic                upd;
  logic signed [DW-1:0] xl_q, yl_q, yc_q, yh_q;
  logic                frz_q;
  logic signed [DW:0]   err_q;
  logic signed [PW-1:0] prod_a, prod_b;

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_ERR;
      S_ERR:   state_nxt = S_GRAD;
      S_GRAD:  state_nxt = S_UPD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == S_IDLE);
    upd      = (state == S_UPD);
  end

  // Tuple is captured at accept so the source may change its inputs immediately after.
  always_ff @(posedge clk) begin
    if (rst) begin
      xl_q       <= '0;
      yl_q       <= '0;
      yc_q       <= '0;
      yh_q       <= '0;
      frz_q      <= 1'b0;
      err_q      <= '0;
      prod_a     <= '0;
      prod_b     <= '0;
      coef_valid <= 1'b0;
    end else begin
      if (in_ready && in_valid) begin
        xl_q  <= in_x_last;
        yl_q  <= in_y_last;
        yc_q  <= in_y_current;
        yh_q  <= in_y_hat;
        frz_q <= freeze;
      end
      if (state == S_ERR)
        err_q <= (DW+1)'(yc_q) - (DW+1)'(yh_q);
      if (state == S_GRAD) begin
        prod_a <= PW'(err_q) * PW'(yl_q);
        prod_b <= PW'(err_q) * PW'(xl_q);
      end
      coef_valid <= upd;
    end
  end

  assign err = err_q;

  lms_coef_upd #(.DW(DW), .MU_SHIFT(MU_SHIFT), .INIT(A_INIT)) u_upd_a (
    .clk  (clk),
    .rst  (rst),
    .upd  (upd),
    .en   (~frz_q),
    .prod (prod_a),
    .coef (a_hat)
  );

  lms_coef_upd #(.DW(DW), .MU_SHIFT(MU_SHIFT), .INIT(B_INIT)) u_upd_b (
    .clk  (clk),
    .rst  (rst),
    .upd  (upd),
    .en   (~frz_q),
    .prod (prod_b),
    .coef (b_hat)
  );

endmodule

// File: tb/tb_lms_backward.sv
// Scoreboard bench for lms_backward: directed tuples push hand-computed results, a monitor checks on coef_valid.
module tb_lms_backward;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        in_x_last = '0;
  logic [7:0]        in_y_last = '0;
  logic [7:0]        in_y_current = '0;
  logic [7:0]        in_y_hat = '0;
  logic              freeze = 1'b0;
  logic signed [7:0] a_hat;
  logic signed [7:0] b_hat;
  logic signed [8:0] err;
  logic              coef_valid;

  typedef struct {
    int e;
    int a;
    int b;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   acc_cnt  = 0;

  lms_backward #(.DW(8), .MU_SHIFT(2), .A_INIT(0), .B_INIT(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x_last    (in_x_last),
    .in_y_last    (in_y_last),
    .in_y_current (in_y_current),
    .in_y_hat     (in_y_hat),
    .freeze       (freeze),
    .a_hat        (a_hat),
    .b_hat        (b_hat),
    .err          (err),
    .coef_valid   (coef_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
    end
  endtask

  always @(posedge clk)
    if (!rst && in_valid && in_ready) acc_cnt++;

  // Monitor: every coef_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t t;
    if (coef_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_coef_valid actual=1 expected=0 a=%0d b=%0d", a_hat, b_hat);
      end else begin
        t = q.pop_front();
        chk("sb_err", err, t.e);
        chk("sb_a_hat", a_hat, t.a);
        chk("sb_b_hat", b_hat, t.b);
      end
    end
  end

  task automatic drive(input int x, input int yl, input int y, input int yh, input logic frz);
    in_x_last    = 8'(x);
    in_y_last    = 8'(yl);
    in_y_current = 8'(y);
    in_y_hat     = 8'(yh);
    freeze       = frz;
  endtask

  // Reset held 2 cycles with in_valid asserted: reset must win over the handshake.
  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_a_hat", a_hat, 0);
    chk("rst_b_hat", b_hat, 0);
    chk("rst_err", err, 0);
    chk("rst_coef_valid", coef_valid, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  task automatic send(input int x, input int yl, input int y, input int yh, input logic frz,
                      input int ee, input int ea, input int eb);
    exp_t t;
    int   n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", in_ready, 1);
    drive(x, yl, y, yh, frz);
    in_valid = 1'b1;
    t.e = ee; t.a = ea; t.b = eb;
    q.push_back(t);
    @(negedge clk);
    in_valid = 1'b0;
    drive(0, 0, 0, 0, 1'b0);
    @(negedge clk);
    chk("err_after_t1", err, ee);
    @(negedge clk);
    chk("cv_low_in_upd", coef_valid, 0);
    @(negedge clk);
    chk("cv_after_t3", coef_valid, 1);
    chk("ready_after_upd", in_ready, 1);
  endtask

  initial begin
    int c0;
    exp_t t;

    do_reset();

    // Basic update: e=16, gb=(16*2)>>>2=8, ga=0.
    send(2, 0, 16, 0, 1'b0, 16, 0, 8);

    // Negative error from 0/0: e=-16, ga=-64>>>2=-16, gb=-32>>>2=-8.
    do_reset();
    send(2, 4, 0, 16, 1'b0, -16, -16, -8);

    // Preload b_hat to 120 in two steps of 60, then push past the positive limit.
    do_reset();
    send(4, 0, 60, 0, 1'b0, 60, 0, 60);
    send(4, 0, 60, 0, 1'b0, 60, 0, 120);
`ifdef LMS_SAT_EN
    send(4, 0, 64, 0, 1'b0, 64, 0, 127);
`else
    send(4, 0, 64, 0, 1'b0, 64, 0, -72);
`endif

    // Freeze: error still reported, coefficients held.
    do_reset();
    send(2, 0, 16, 0, 1'b1, 16, 0, 0);

    // Backpressure: in_valid held 6 cycles yields exactly two transfers.
    @(negedge clk);
    c0 = acc_cnt;
    drive(2, 0, 16, 0, 1'b1);
    t.e = 16; t.a = 0; t.b = 0;
    q.push_back(t);
    q.push_back(t);
    in_valid = 1'b1;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("bp_transfers", acc_cnt - c0, 2);
    chk("bp_queue_drained", q.size(), 0);

    // Reset mid-operation: build b_hat=8, then abort a second sample during GRAD.
    send(2, 0, 16, 0, 1'b0, 16, 0, 8);
    @(negedge clk);
    drive(2, 4, 0, 16, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_a_hat", a_hat, 0);
    chk("midrst_b_hat", b_hat, 0);
    chk("midrst_coef_valid", coef_valid, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_b_hold", b_hat, 0);
    chk("final_queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
